// File: rtl/posit_dot_sequencer_if.sv
// Control, operand-stream and result signals of the posit dot-product sequencer.
// The slave side belongs to the sequencer and the master side to whatever drives it.
interface posit_dot_sequencer_if #(
    parameter int N     = 32,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [N-1:0]     init;
    logic             op_sub;

    // Valid/ready handshake on both streams: a transfer happens on a rising
    // edge where valid and ready are both high. Ready never depends
    // combinationally on valid, and the sender holds its data until then.
    logic             a_valid;
    logic             a_ready;
    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;

    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     result;
    logic             nar;
    logic             busy;

    modport slave (
        input  start, len, init, op_sub,
        input  a_valid, a_in, b_in,
        output a_ready,
        output res_valid, result, nar, busy,
        input  res_ready
    );

    modport master (
        output start, len, init, op_sub,
        output a_valid, a_in, b_in,
        input  a_ready,
        input  res_valid, result, nar, busy,
        output res_ready
    );
endinterface

// File: rtl/posit_dot_sequencer.sv
// Multi-cycle sequencer around a combinational posit FMA. It computes
// init +/- sum(a[i]*b[i]) by feeding the FMA one registered pair per LOAD/EXEC step.
module posit_dot_sequencer #(
    parameter int N     = 32,
    parameter int ES    = 2,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    posit_dot_sequencer_if.slave bus,
    output logic [N-1:0]         fma_in1,
    output logic [N-1:0]         fma_in2,
    output logic [N-1:0]         fma_in3,
    output logic                 fma_op_N,
    output logic                 fma_op_sub,
    input  logic [N-1:0]         fma_out,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    // A posit needs at least sign, two regime bits and its exponent field.
    if (ES < 0 || ES > N - 3) begin : g_bad_es
        $error("posit_dot_sequencer: ES does not fit in N");
    end

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] cnt;
    logic [N-1:0]     acc;
    logic             sub_q;
    logic             nar_q;
    logic             a_ready;
    logic             res_valid;
    logic             busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_ready   = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    state_d = (bus.len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                a_ready = 1'b1;
                if (bus.a_valid) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = (cnt == LEN_W'(1)) ? DONE : LOAD;
            end
            DONE: begin
                res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The accumulator doubles as FMA IN3, so it only changes at IDLE start and at
    // EXEC, which keeps the result stable for the whole of DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            fma_in1 <= '0;
            fma_in2 <= '0;
            sub_q   <= 1'b0;
            nar_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        cnt   <= bus.len;
                        acc   <= bus.init;
                        sub_q <= bus.op_sub;
                        nar_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.a_valid) begin
                        fma_in1 <= bus.a_in;
                        fma_in2 <= bus.b_in;
                    end
                end
                EXEC: begin
                    acc <= fma_out;
                    cnt <= cnt - LEN_W'(1);
                    if (fma_out == NAR) begin
                        nar_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fma_in3       = acc;
    assign fma_op_N      = 1'b0;
    assign fma_op_sub    = sub_q;
    assign state_dbg     = state_q;

    assign bus.a_ready   = a_ready;
    assign bus.res_valid = res_valid;
    assign bus.result    = acc;
    assign bus.nar       = nar_q;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_posit_dot_sequencer.sv
// Bench for posit_dot_sequencer: a real-valued posit FMA stands in for the datapath,
// and a scoreboard compares each result against the dot product computed from the pairs.
module tb_posit_dot_sequencer;

    localparam int N     = 32;
    localparam int LEN_W = 8;
    localparam logic [31:0] NAR = 32'h8000_0000;
    localparam logic [31:0] P0  = 32'h0000_0000;
    localparam logic [31:0] P1  = 32'h4000_0000;
    localparam logic [31:0] P2  = 32'h4800_0000;
    localparam logic [31:0] P4  = 32'h5000_0000;
    localparam logic [31:0] P5  = 32'h5200_0000;
    localparam logic [31:0] P6  = 32'h5400_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  fma_in1;
    logic [N-1:0]  fma_in2;
    logic [N-1:0]  fma_in3;
    logic          fma_op_N;
    logic          fma_op_sub;
    logic [N-1:0]  fma_out;
    logic [1:0]    state_dbg;

    posit_dot_sequencer_if #(.N(N), .LEN_W(LEN_W)) bus ();

    posit_dot_sequencer #(.N(N), .ES(2), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fma_in1    (fma_in1),
        .fma_in2    (fma_in2),
        .fma_in3    (fma_in3),
        .fma_op_N   (fma_op_N),
        .fma_op_sub (fma_op_sub),
        .fma_out    (fma_out),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    int t0  = 0;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- posit <-> real (N=32, ES=2) ----------------
    function automatic real p2r(logic [31:0] p);
        logic [31:0] x;
        int          i, r, e, k;
        real         f, w, v;
        bit          s;
        if (p == 32'h0 || p == NAR) return 0.0;
        s = p[31];
        x = s ? -p : p;
        i = 30;
        if (x[30]) begin
            r = -1;
            while (i >= 0 && x[i]) begin r++; i--; end
        end else begin
            r = 0;
            while (i >= 0 && !x[i]) begin r--; i--; end
        end
        i--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2;
            if (i >= 0) begin e = e + int'(x[i]); i--; end
        end
        f = 1.0;
        w = 0.5;
        while (i >= 0) begin
            if (x[i]) f = f + w;
            w = w / 2.0;
            i--;
        end
        k = 4 * r + e;
        v = f;
        while (k > 0) begin v = v * 2.0; k--; end
        while (k < 0) begin v = v / 2.0; k++; end
        return s ? -v : v;
    endfunction

    function automatic logic [31:0] r2p(real v);
        logic [30:0] body;
        logic [31:0] pos;
        int          n, k, r, e;
        real         a, f;
        bit          s;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        a = s ? -v : v;
        k = 0;
        while (a >= 2.0) begin a = a / 2.0; k++; end
        while (a < 1.0)  begin a = a * 2.0; k--; end
        r = (k >= 0) ? k / 4 : -((3 - k) / 4);
        e = k - 4 * r;
        body = '0;
        n = 0;
        if (r >= 0) begin
            for (int j = 0; j <= r; j++) begin if (n < 31) body[30-n] = 1'b1; n++; end
            if (n < 31) body[30-n] = 1'b0;
            n++;
        end else begin
            for (int j = 0; j < -r; j++) begin if (n < 31) body[30-n] = 1'b0; n++; end
            if (n < 31) body[30-n] = 1'b1;
            n++;
        end
        for (int j = 1; j >= 0; j--) begin if (n < 31) body[30-n] = e[j]; n++; end
        f = a - 1.0;
        while (n < 31) begin
            f = f * 2.0;
            if (f >= 1.0) begin body[30-n] = 1'b1; f = f - 1.0; end
            n++;
        end
        pos = {1'b0, body};
        return s ? -pos : pos;
    endfunction

    // Stand-in FMA: OUT = IN3 +/- IN1*IN2, NaR in any input gives NaR.
    always_comb begin
        if (fma_in1 == NAR || fma_in2 == NAR || fma_in3 == NAR)
            fma_out = NAR;
        else if (fma_op_sub)
            fma_out = r2p(p2r(fma_in3) - p2r(fma_in1) * p2r(fma_in2));
        else
            fma_out = r2p(p2r(fma_in3) + p2r(fma_in1) * p2r(fma_in2));
    end

    // ---------------- reference model ----------------
    logic [31:0] pa[$];
    logic [31:0] pb[$];

    function automatic logic [32:0] model(logic [31:0] ini, bit sub, int l);
        real acc;
        bit  saw_nar;
        if (l == 0) return {1'b0, ini};
        saw_nar = (ini == NAR);
        acc = p2r(ini);
        for (int i = 0; i < l; i++) begin
            if (pa[i] == NAR || pb[i] == NAR) saw_nar = 1'b1;
            else if (sub) acc = acc - p2r(pa[i]) * p2r(pb[i]);
            else          acc = acc + p2r(pa[i]) * p2r(pb[i]);
        end
        if (saw_nar) return {1'b1, NAR};
        return {1'b0, r2p(acc)};
    endfunction

    function automatic logic [31:0] rand_posit(bit allow_nar);
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = P0;
            1:       v = P1;
            2:       v = P2;
            3:       v = P4;
            4:       v = 32'h3800_0000;
            5:       v = 32'h4400_0000;
            default: v = 32'h4C00_0000;
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        if (allow_nar && $urandom_range(0, 15) == 0) v = NAR;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_err    = 0;
    logic [N:0]  exp_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic        prev_valid = 1'b0;
    logic [31:0] prev_result = '0;

    always @(negedge clk) begin
        logic [N:0] e;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.res_valid && prev_valid) check("result_hold", bus.result, prev_result);
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", bus.result, e[31:0]);
                    check("nar", bus.nar, e[32]);
                    check("fma_op_N", fma_op_N, 0);
                end
            end
            prev_valid  = bus.res_valid && !bus.res_ready;
            prev_result = bus.result;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_idle(string tag);
        check({tag, "_state"},   state_dbg, 0);
        check({tag, "_busy"},    bus.busy, 0);
        check({tag, "_a_ready"}, bus.a_ready, 0);
        check({tag, "_res_vld"}, bus.res_valid, 0);
        check({tag, "_nar"},     bus.nar, 0);
        check({tag, "_result"},  bus.result, 0);
        check({tag, "_in1"},     fma_in1, 0);
        check({tag, "_in2"},     fma_in2, 0);
        check({tag, "_in3"},     fma_in3, 0);
        check({tag, "_op_sub"},  fma_op_sub, 0);
        check({tag, "_op_N"},    fma_op_N, 0);
    endtask

    task automatic do_start(logic [7:0] l, logic [31:0] ini, bit sub);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.len    = l;
        bus.init   = ini;
        bus.op_sub = sub;
        t0 = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic feed_pair(logic [31:0] a, logic [31:0] b, int gap, bit chk_ready);
        bit hs;
        int guard;
        bus.a_valid = 1'b0;
        bus.a_in    = a;
        bus.b_in    = b;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (chk_ready) check("a_ready_stall", bus.a_ready, 1);
            @(posedge clk); #1;
        end
        bus.a_valid = 1'b1;
        guard = 0;
        hs    = 1'b0;
        while (!hs && guard < 100) begin
            @(negedge clk);
            hs = bus.a_ready;
            @(posedge clk); #1;
            guard++;
        end
        bus.a_valid = 1'b0;
        if (!hs) check("a_handshake_timeout", 0, 1);
    endtask

    task automatic wait_result(int exp_lat, int r_stall);
        int guard;
        bus.res_ready = (r_stall == 0);
        guard = 0;
        @(negedge clk);
        while (!bus.res_valid && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.res_valid) begin
            check("res_timeout", 0, 1);
            return;
        end
        if (exp_lat >= 0) check("latency", cyc - t0, exp_lat);
        for (int i = 0; i < r_stall; i++) begin
            check("res_valid_stall", bus.res_valid, 1);
            check("busy_done", bus.busy, 1);
            @(posedge clk); #1;
            if (i == r_stall - 1) bus.res_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after", {bus.res_valid, bus.busy}, 0);
    endtask

    task automatic run(logic [7:0] l, logic [31:0] ini, bit sub, int max_gap, int r_stall,
                       logic [32:0] e);
        bit any_gap;
        int g;
        any_gap = 1'b0;
        exp_q.push_back(e);
        do_start(l, ini, sub);
        for (int i = 0; i < int'(l); i++) begin
            g = $urandom_range(0, max_gap);
            if (g != 0) any_gap = 1'b1;
            feed_pair(pa[i], pb[i], g, 1'b0);
        end
        wait_result(any_gap ? -1 : 1 + 2 * int'(l), r_stall);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  l;
        logic [31:0] ini;
        bit          sub;

        bus.start     = 1'b0;
        bus.len       = '0;
        bus.init      = '0;
        bus.op_sub    = 1'b0;
        bus.a_valid   = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.res_ready = 1'b0;

        // reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        repeat (4) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_a_ready", bus.a_ready, 0);
        end

        // basic run: 0 + 1*2 + 2*1 = 4
        pa = '{P1, P2};
        pb = '{P2, P1};
        run(8'd2, P0, 1'b0, 0, 0, {1'b0, P4});

        // subtract with backpressure: 6 - 1*2 = 4
        pa = '{P1};
        pb = '{P2};
        exp_q.push_back({1'b0, P4});
        do_start(8'd1, P6, 1'b1);
        feed_pair(P1, P2, 3, 1'b1);
        wait_result(-1, 4);

        // zero length, with start asserted during the DONE->IDLE cycle
        exp_q.push_back({1'b0, P2});
        do_start(8'd0, P2, 1'b0);
        bus.res_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = 8'd3;
        @(negedge clk);
        check("zero_len_valid", bus.res_valid, 1);
        check("zero_len_latency", cyc - t0, 1);
        check("zero_len_a_ready", bus.a_ready, 0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("start_in_done_ignored", bus.busy, 0);
            check("zero_len_a_ready_idle", bus.a_ready, 0);
        end

        // NaR in pair 2 of 3
        pa = '{P1, NAR, P1};
        pb = '{P1, P1, P2};
        exp_q.push_back({1'b1, NAR});
        do_start(8'd3, P0, 1'b0);
        feed_pair(pa[0], pb[0], 0, 1'b0);
        feed_pair(pa[1], pb[1], 0, 1'b0);
        @(negedge clk);
        check("nar_before_exec", bus.nar, 0);
        feed_pair(pa[2], pb[2], 0, 1'b0);
        @(negedge clk);
        check("nar_sticky", bus.nar, 1);
        wait_result(-1, 0);

        // abort during EXEC of pair 2 of 4, then a clean run: 1 + 2*2 = 5
        do_start(8'd4, P1, 1'b1);
        feed_pair(P2, P2, 0, 1'b0);
        feed_pair(P2, P4, 0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("abort");
        pa = '{P2};
        pb = '{P2};
        run(8'd1, P1, 1'b0, 0, 0, {1'b0, P5});

        // randomized runs against the dot-product model
        for (int t = 0; t < 40; t++) begin
            l   = 8'($urandom_range(0, 10));
            ini = rand_posit(1'b0);
            sub = 1'($urandom_range(0, 1));
            pa.delete();
            pb.delete();
            for (int i = 0; i < int'(l); i++) begin
                pa.push_back(rand_posit(1'b1));
                pb.push_back(rand_posit(1'b1));
            end
            run(l, ini, sub, (t % 3 == 0) ? 0 : 2, $urandom_range(0, 3), model(ini, sub, int'(l)));
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
